// File: rtl/sample_delay_line.sv
// Sample-counted programmable delay line.
// Output sample n is input sample n-D, two cycles after input n is accepted.
module sample_delay_line #(
    parameter int MAX_DELAY  = 128,
    parameter int DATA_WIDTH = 32,
    localparam int AW = $clog2(MAX_DELAY)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  zero_fill,
    input  logic [AW-1:0]         delay,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  valid_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  primed,
    output logic [AW:0]           fill_level
);

    logic [DATA_WIDTH-1:0] mem [MAX_DELAY];
    logic [DATA_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0] s1_fdat;
    logic [AW-1:0]         wptr;
    logic [AW-1:0]         cur_d;
    logic [AW-1:0]         raddr;
    logic                  live;
    logic                  accept;
    logic                  chg;
    logic                  hit;
    logic                  s1_v;
    logic                  s1_zero;
    logic                  s1_fwd;

    assign accept = valid_in && !flush;
    assign chg    = (delay != cur_d);
    // A read is only launched once enough samples back the active delay.
    assign hit    = accept && !chg && (fill_level == {1'b0, cur_d});
    assign raddr  = wptr - cur_d;
    // live keeps primed low while held in reset, before cur_d is loaded.
    assign primed = live && (fill_level == {1'b0, cur_d});

    // Storage: one write and one synchronous read per cycle.
    always_ff @(posedge clk) begin
        if (accept) mem[wptr] <= data_in;
        if (hit)    rd_q      <= mem[raddr];
    end

    // Write pointer, active delay and fill tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr       <= '0;
            cur_d      <= '0;
            fill_level <= '0;
            live       <= 1'b0;
        end else begin
            live <= 1'b1;
            if (flush) begin
                wptr       <= '0;
                fill_level <= '0;
                cur_d      <= delay;
            end else begin
                if (accept) wptr <= wptr + 1'b1;
                if (chg) begin
                    cur_d      <= delay;
                    fill_level <= '0;
                end else if (accept && !hit) begin
                    fill_level <= fill_level + 1'b1;
                end
            end
        end
    end

    // Pipeline stage 1: launch decision alongside the memory read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v    <= 1'b0;
            s1_zero <= 1'b0;
            s1_fwd  <= 1'b0;
            s1_fdat <= '0;
        end else if (flush) begin
            s1_v <= 1'b0;
        end else begin
            s1_v    <= hit || (accept && zero_fill);
            s1_zero <= !hit;
            s1_fwd  <= (cur_d == '0);
            s1_fdat <= data_in;
        end
    end

    // Pipeline stage 2: registered output, data held while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            data_out  <= '0;
        end else if (flush) begin
            valid_out <= 1'b0;
        end else begin
            valid_out <= s1_v;
            if (s1_v) begin
                data_out <= s1_zero ? '0 :
                            s1_fwd  ? s1_fdat : rd_q;
            end
        end
    end

endmodule

// File: tb/tb_sample_delay_line.sv
// Directed and randomized bench for sample_delay_line.
// Expected outputs come from a sample-history reference model.
module tb_sample_delay_line;

    localparam int MD = 128;
    localparam int DW = 32;
    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          zero_fill = 1'b0;
    logic [AW-1:0] delay = '0;
    logic          valid_in = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          valid_out;
    logic [DW-1:0] data_out;
    logic          primed;
    logic [AW:0]   fill_level;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: every accepted sample since the last flush/reset.
    logic [DW-1:0] hist[$];
    int            m_d;
    int            m_f;
    bit            m_live;
    bit            p1_v;
    logic [DW-1:0] p1_d;
    bit            e_v;
    logic [DW-1:0] e_d;

    sample_delay_line #(.MAX_DELAY(MD), .DATA_WIDTH(DW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .zero_fill(zero_fill),
        .delay(delay),
        .valid_in(valid_in),
        .data_in(data_in),
        .valid_out(valid_out),
        .data_out(data_out),
        .primed(primed),
        .fill_level(fill_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        m_d    = 0;
        m_f    = 0;
        m_live = 0;
        p1_v   = 0;
        p1_d   = '0;
        e_v    = 0;
        e_d    = '0;
    endtask

    task automatic check_outputs();
        chk("valid_out", 32'(valid_out), 32'(e_v));
        chk("data_out", data_out, e_d);
        chk("fill_level", 32'(fill_level), 32'(m_f));
        chk("primed", 32'(primed), 32'(m_live && (m_f == m_d)));
    endtask

    // One clock: apply inputs, predict, advance, check.
    task automatic step(input bit v, input logic [DW-1:0] d, input bit fl);
        bit            lv;
        bit            chg;
        logic [DW-1:0] ld;
        int            n;
        valid_in = v;
        data_in  = d;
        flush    = fl;
        lv = 0;
        ld = '0;
        if (fl) begin
            hist.delete();
            m_d = int'(delay);
            m_f = 0;
        end else begin
            chg = (int'(delay) != m_d);
            if (v) begin
                hist.push_back(d);
                n = hist.size() - 1;
                if (!chg && m_f == m_d) begin
                    lv = 1;
                    ld = (n >= m_d) ? hist[n - m_d] : '0;
                end else begin
                    lv = zero_fill;
                    if (!chg) m_f++;
                end
            end
            if (chg) begin
                m_d = int'(delay);
                m_f = 0;
            end
        end
        @(posedge clk);
        m_live = 1;
        if (fl) begin
            e_v  = 0;
            p1_v = 0;
        end else begin
            e_v = p1_v;
            if (p1_v) e_d = p1_d;
            p1_v = lv;
            p1_d = ld;
        end
        #1;
        check_outputs();
    endtask

    task automatic ramp(input int count, inout logic [DW-1:0] val);
        for (int i = 0; i < count; i++) begin
            step(1'b1, val, 1'b0);
            val++;
        end
    endtask

    task automatic idle(input int count);
        for (int i = 0; i < count; i++) step(1'b0, $urandom, 1'b0);
    endtask

    initial begin
        logic [DW-1:0] r;
        bit            pat [5];
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        model_reset();

        // Reset state.
        delay = 7'd5;
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Continuous ramp, D=5, no prefill.
        step(1'b0, '0, 1'b1);
        r = 1;
        ramp(20, r);
        idle(3);

        // Zero-prefill ramp, D=3.
        delay = 7'd3;
        zero_fill = 1'b1;
        step(1'b0, '0, 1'b1);
        r = 1;
        ramp(10, r);
        idle(3);

        // D=0 with gapped valid.
        delay = 7'd0;
        zero_fill = 1'b0;
        step(1'b0, '0, 1'b1);
        for (int k = 0; k < 4; k++)
            for (int i = 0; i < 5; i++) step(pat[i], $urandom, 1'b0);
        for (int i = 0; i < 20; i++) step(($urandom_range(0, 1) == 1), $urandom, 1'b0);
        idle(3);

        // Maximum delay across pointer wraps.
        delay = 7'(MD - 1);
        step(1'b0, '0, 1'b1);
        r = 1;
        ramp(300, r);
        idle(3);

        // Delay change 4 -> 2 mid-stream.
        delay = 7'd4;
        step(1'b0, '0, 1'b1);
        r = 100;
        ramp(10, r);
        delay = 7'd2;
        ramp(10, r);
        idle(3);

        // Flush together with valid while primed.
        delay = 7'd4;
        step(1'b0, '0, 1'b1);
        r = 200;
        ramp(8, r);
        step(1'b1, 32'hdead_beef, 1'b1);
        ramp(8, r);

        // Asynchronous reset pulse mid-stream.
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        #2;
        rst_n = 1'b1;
        ramp(8, r);
        idle(3);

        // Randomized traffic with gaps, delay changes, prefill toggles, flushes.
        delay = 7'($urandom_range(0, 15));
        step(1'b0, '0, 1'b1);
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) delay = 7'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) zero_fill = ~zero_fill;
            step(($urandom_range(0, 3) != 0), $urandom,
                 ($urandom_range(0, 79) == 0));
        end
        idle(3);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
